// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic lamp conflict monitor: fault codes,
// lamp bit positions within a 3-bit approach vector and a one-hot helper.
package traffic_pkg;

  // Fault codes; a lower value has higher priority.
  localparam logic [2:0] FLT_NONE     = 3'd0;
  localparam logic [2:0] FLT_ONEHOT   = 3'd1;
  localparam logic [2:0] FLT_CONFLICT = 3'd2;
  localparam logic [2:0] FLT_TRANS    = 3'd3;
  localparam logic [2:0] FLT_SHORT_Y  = 3'd4;
  localparam logic [2:0] FLT_WDOG     = 3'd5;

  // Bit positions of the lamps inside an approach vector {G,Y,R}.
  localparam int LAMP_R = 0;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 2;

  // Legal single-lamp patterns of an approach.
  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b100;

  // True when exactly one lamp of the approach is lit.
  function automatic logic is_one_hot3(input logic [2:0] lamp);
    return (lamp == LAMP_RED) || (lamp == LAMP_YEL) || (lamp == LAMP_GRN);
  endfunction

endpackage

// File: rtl/lamp_approach_checker.sv
// Per-approach lamp checks: one-hot pattern, legal colour sequence and
// minimum yellow duration. Owns the yellow run-length counter.
module lamp_approach_checker
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] lamp,
  input  logic [2:0] prev_lamp,
  input  logic       prev_valid,
  input  logic       clr,
  output logic       onehot_err,
  output logic       trans_err,
  output logic       short_err
);

  localparam int             YW   = $clog2(MIN_YELLOW_CYC + 1);
  localparam logic [YW-1:0]  YSAT = YW'(MIN_YELLOW_CYC);

  logic [YW-1:0] ycnt_r;
  logic          legal_s;

  // Allowed moves: hold, G->Y, Y->R, R->G.
  always_comb begin
    legal_s = 1'b0;
    case (prev_lamp)
      LAMP_GRN: legal_s = (lamp == LAMP_GRN) || (lamp == LAMP_YEL);
      LAMP_YEL: legal_s = (lamp == LAMP_YEL) || (lamp == LAMP_RED);
      LAMP_RED: legal_s = (lamp == LAMP_RED) || (lamp == LAMP_GRN);
      default:  legal_s = 1'b0;
    endcase
  end

  assign onehot_err = ~is_one_hot3(lamp);
  assign trans_err  = prev_valid & ~legal_s;
  assign short_err  = prev_valid & (prev_lamp == LAMP_YEL) & (lamp == LAMP_RED)
                    & (ycnt_r < YSAT);

  // Yellow run length; a yellow that starts with no valid history is
  // treated as already long enough so it can never be flagged short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ycnt_r <= '0;
    end else if (clr) begin
      ycnt_r <= '0;
    end else if (lamp[LAMP_Y]) begin
      if (!prev_valid) begin
        ycnt_r <= YSAT;
      end else if (ycnt_r != YSAT) begin
        ycnt_r <= ycnt_r + YW'(1);
      end else begin
        ycnt_r <= ycnt_r;
      end
    end else begin
      ycnt_r <= '0;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp-side safety monitor. Legal lamp vectors pass through one register
// stage; the first fault latches and forces flashing red on both approaches
// until cleared with a safe all-red input.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW_CYC = 2,
  parameter int MAX_PHASE_CYC  = 64,
  parameter int FLASH_HALF_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       MR,
  input  logic       MY,
  input  logic       MG,
  input  logic       SR,
  input  logic       SY,
  input  logic       SG,
  input  logic       fault_clr,
  output logic       o_MR,
  output logic       o_MY,
  output logic       o_MG,
  output logic       o_SR,
  output logic       o_SY,
  output logic       o_SG,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int             WW       = $clog2(MAX_PHASE_CYC + 1);
  localparam logic [WW-1:0]  WSAT     = WW'(MAX_PHASE_CYC);
  localparam int             FW       = $clog2(FLASH_HALF_CYC + 1);
  localparam logic [FW-1:0]  FLAST    = FW'(FLASH_HALF_CYC - 1);
  localparam logic [5:0]     SAFE_VEC = {LAMP_RED, LAMP_RED};

  logic [2:0]    main_s, side_s;
  logic [5:0]    vec_s;
  logic [5:0]    prev_r;
  logic          prev_valid_r;
  logic [2:0]    main_out_r, side_out_r;
  logic          fault_r;
  logic [2:0]    code_r;
  logic [WW-1:0] wd_r;
  logic          flash_r;
  logic [FW-1:0] fcnt_r;

  logic          m_oh_s, m_tr_s, m_sy_s;
  logic          s_oh_s, s_tr_s, s_sy_s;
  logic          conflict_s, clr_s;
  logic [WW-1:0] wd_run_s;
  logic [2:0]    code_s;
  logic          flash_nx_s;
  logic [FW-1:0] fcnt_nx_s;

  assign main_s     = {MG, MY, MR};
  assign side_s     = {SG, SY, SR};
  assign vec_s      = {side_s, main_s};
  assign conflict_s = (MG | MY) & (SG | SY);
  assign clr_s      = fault_r & fault_clr & (vec_s == SAFE_VEC);

  lamp_approach_checker #(.MIN_YELLOW_CYC(MIN_YELLOW_CYC)) u_main (
    .clk(clk), .rst(rst), .lamp(main_s), .prev_lamp(prev_r[2:0]),
    .prev_valid(prev_valid_r), .clr(clr_s),
    .onehot_err(m_oh_s), .trans_err(m_tr_s), .short_err(m_sy_s)
  );

  lamp_approach_checker #(.MIN_YELLOW_CYC(MIN_YELLOW_CYC)) u_side (
    .clk(clk), .rst(rst), .lamp(side_s), .prev_lamp(prev_r[5:3]),
    .prev_valid(prev_valid_r), .clr(clr_s),
    .onehot_err(s_oh_s), .trans_err(s_tr_s), .short_err(s_sy_s)
  );

  // Number of consecutive cycles the current vector has been presented.
  always_comb begin
    wd_run_s = WW'(1);
    if (prev_valid_r && (vec_s == prev_r)) begin
      if (wd_r == WSAT) begin
        wd_run_s = WSAT;
      end else begin
        wd_run_s = wd_r + WW'(1);
      end
    end else begin
      wd_run_s = WW'(1);
    end
  end

  // Priority encoder: lowest fault code wins.
  always_comb begin
    code_s = FLT_NONE;
    if (m_oh_s | s_oh_s) begin
      code_s = FLT_ONEHOT;
    end else if (conflict_s) begin
      code_s = FLT_CONFLICT;
    end else if (m_tr_s | s_tr_s) begin
      code_s = FLT_TRANS;
    end else if (m_sy_s | s_sy_s) begin
      code_s = FLT_SHORT_Y;
    end else if (wd_run_s == WSAT) begin
      code_s = FLT_WDOG;
    end else begin
      code_s = FLT_NONE;
    end
  end

  // Next flash phase: toggle after FLASH_HALF_CYC cycles in the same phase.
  always_comb begin
    flash_nx_s = flash_r;
    fcnt_nx_s  = fcnt_r;
    if (fcnt_r == FLAST) begin
      flash_nx_s = ~flash_r;
      fcnt_nx_s  = '0;
    end else begin
      flash_nx_s = flash_r;
      fcnt_nx_s  = fcnt_r + FW'(1);
    end
  end

  // Fault latch, history, watchdog, flasher and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      main_out_r   <= LAMP_RED;
      side_out_r   <= LAMP_RED;
      fault_r      <= 1'b0;
      code_r       <= FLT_NONE;
      wd_r         <= '0;
      flash_r      <= 1'b1;
      fcnt_r       <= '0;
    end else if (!fault_r) begin
      prev_r       <= vec_s;
      prev_valid_r <= 1'b1;
      wd_r         <= wd_run_s;
      if (code_s != FLT_NONE) begin
        fault_r    <= 1'b1;
        code_r     <= code_s;
        main_out_r <= LAMP_RED;
        side_out_r <= LAMP_RED;
        flash_r    <= 1'b1;
        fcnt_r     <= '0;
      end else begin
        main_out_r <= main_s;
        side_out_r <= side_s;
      end
    end else if (clr_s) begin
      fault_r      <= 1'b0;
      code_r       <= FLT_NONE;
      prev_r       <= vec_s;
      prev_valid_r <= 1'b0;
      wd_r         <= '0;
      main_out_r   <= main_s;
      side_out_r   <= side_s;
      flash_r      <= 1'b1;
      fcnt_r       <= '0;
    end else begin
      prev_r     <= vec_s;
      wd_r       <= wd_run_s;
      flash_r    <= flash_nx_s;
      fcnt_r     <= fcnt_nx_s;
      main_out_r <= {2'b00, flash_nx_s};
      side_out_r <= {2'b00, flash_nx_s};
    end
  end

  assign o_MR       = main_out_r[LAMP_R];
  assign o_MY       = main_out_r[LAMP_Y];
  assign o_MG       = main_out_r[LAMP_G];
  assign o_SR       = side_out_r[LAMP_R];
  assign o_SY       = side_out_r[LAMP_Y];
  assign o_SG       = side_out_r[LAMP_G];
  assign fault      = fault_r;
  assign fault_code = code_r;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Self-checking bench for traffic_conflict_monitor: a directed vector table,
// hand-written multi-cycle sequences and randomized traffic, all compared
// against a rule-level reference model.
module tb_traffic_conflict_monitor;

  localparam int MINY = 2;
  localparam int MAXP = 16;
  localparam int HALF = 2;

  // Vector layout {SG,SY,SR,MG,MY,MR}
  localparam logic [5:0] SAFE  = 6'b001_001;
  localparam logic [5:0] MG_SR = 6'b001_100;
  localparam logic [5:0] MY_SR = 6'b001_010;
  localparam logic [5:0] MR_SG = 6'b100_001;
  localparam logic [5:0] MR_SY = 6'b010_001;
  localparam logic [5:0] MG_SG = 6'b100_100;
  localparam logic [5:0] BOTH  = 6'b100_110;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       fclr = 1'b0;
  logic [5:0] vin  = SAFE;
  logic       o_MR, o_MY, o_MG, o_SR, o_SY, o_SG, flt;
  logic [2:0] code;
  logic [5:0] o_vec;

  int errors = 0;
  int checks = 0;

  assign o_vec = {o_SG, o_SY, o_SR, o_MG, o_MY, o_MR};

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .MIN_YELLOW_CYC(MINY), .MAX_PHASE_CYC(MAXP), .FLASH_HALF_CYC(HALF)
  ) dut (
    .clk(clk), .rst(rst),
    .MR(vin[0]), .MY(vin[1]), .MG(vin[2]),
    .SR(vin[3]), .SY(vin[4]), .SG(vin[5]),
    .fault_clr(fclr),
    .o_MR(o_MR), .o_MY(o_MY), .o_MG(o_MG),
    .o_SR(o_SR), .o_SY(o_SY), .o_SG(o_SG),
    .fault(flt), .fault_code(code)
  );

  // ---------------- reference model ----------------
  bit         m_fault;
  logic [2:0] m_code;
  logic [5:0] m_out;
  logic [5:0] m_prev;
  bit         m_valid;
  int         m_run;
  int         m_fn;
  int         m_yrun [2];
  bit         m_ypre [2];

  // Colour index: 0 red, 1 yellow, 2 green, -1 not a single lamp.
  function automatic int col(input logic [2:0] l);
    case (l)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_fault = 1'b0; m_code = 3'd0; m_out = SAFE; m_prev = 6'd0;
    m_valid = 1'b0; m_run = 0; m_fn = 0;
    for (int k = 0; k < 2; k++) begin m_yrun[k] = 0; m_ypre[k] = 1'b0; end
  endtask

  task automatic model_step(input logic [5:0] v, input logic c);
    logic [2:0] ap [2];
    logic [2:0] pp [2];
    int         newrun;
    int         cd;
    bit         tr, sh;
    ap[0] = v[2:0];      ap[1] = v[5:3];
    pp[0] = m_prev[2:0]; pp[1] = m_prev[5:3];
    newrun = (m_valid && v == m_prev) ? m_run + 1 : 1;
    if (m_fault && c && v == SAFE) begin
      m_fault = 1'b0; m_code = 3'd0; m_out = v; m_prev = v; m_valid = 1'b0;
      m_run = 0;
      for (int k = 0; k < 2; k++) begin m_yrun[k] = 0; m_ypre[k] = 1'b0; end
      return;
    end
    if (!m_fault) begin
      tr = 1'b0; sh = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (m_valid && col(ap[k]) != col(pp[k]) && col(ap[k]) != (col(pp[k]) + 2) % 3)
          tr = 1'b1;
        if (m_valid && col(pp[k]) == 1 && col(ap[k]) == 0 && !m_ypre[k] && m_yrun[k] < MINY)
          sh = 1'b1;
      end
      cd = 0;
      if ($countones(ap[0]) != 1 || $countones(ap[1]) != 1) cd = 1;
      else if ((ap[0][1] | ap[0][2]) && (ap[1][1] | ap[1][2])) cd = 2;
      else if (tr) cd = 3;
      else if (sh) cd = 4;
      else if (newrun >= MAXP) cd = 5;
      if (cd != 0) begin
        m_fault = 1'b1; m_code = 3'(cd); m_fn = 0; m_out = SAFE;
      end else begin
        m_out = v;
      end
    end else begin
      m_fn++;
      m_out = (((m_fn / HALF) % 2) == 0) ? SAFE : 6'd0;
    end
    for (int k = 0; k < 2; k++) begin
      if (ap[k][1]) begin
        if (m_yrun[k] == 0) m_ypre[k] = !m_valid;
        m_yrun[k]++;
      end else begin
        m_yrun[k] = 0; m_ypre[k] = 1'b0;
      end
    end
    m_prev = v; m_valid = 1'b1; m_run = newrun;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [5:0] v, input logic c, input string name);
    vin = v; fclr = c;
    model_step(v, c);
    @(posedge clk); #1;
    check(name, {6'd0, o_vec, flt, code}, {6'd0, m_out, m_fault, m_code});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [5:0] vec;
    logic       clr;
    logic [5:0] eo;
    logic       ef;
    logic [2:0] ec;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic [5:0] v, input logic c, input logic [5:0] eo,
                     input logic ef, input logic [2:0] ec, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{v, c, eo, ef, ec});
  endtask

  task automatic rand_phase(input int n);
    logic [2:0] a [2];
    int         r;
    for (int i = 0; i < n; i++) begin
      if (m_fault && $urandom_range(0, 3) == 0) begin
        step(SAFE, 1'b1, "rand_clear");
      end else begin
        for (int k = 0; k < 2; k++) begin
          r    = $urandom_range(0, 19);
          a[k] = vin[3*k +: 3];
          if (r < 12) begin
            a[k] = a[k];
          end else if (r < 18) begin
            case (a[k])
              3'b100:  a[k] = 3'b010;
              3'b010:  a[k] = 3'b001;
              3'b001:  a[k] = 3'b100;
              default: a[k] = 3'b001;
            endcase
          end else if (r == 18) begin
            a[k] = 3'($urandom);
          end else begin
            a[k] = 3'b001 << $urandom_range(0, 2);
          end
        end
        step({a[1], a[0]}, ($urandom_range(0, 7) == 0), "rand");
      end
    end
  endtask

  initial begin
    model_reset();
    // Test 1: legal cycle passes through delayed one cycle.
    add(MG_SR, 1'b0, MG_SR, 1'b0, 3'd0, 5);
    add(MY_SR, 1'b0, MY_SR, 1'b0, 3'd0, 2);
    add(SAFE,  1'b0, SAFE,  1'b0, 3'd0, 1);
    add(MR_SG, 1'b0, MR_SG, 1'b0, 3'd0, 5);
    add(MR_SY, 1'b0, MR_SY, 1'b0, 3'd0, 2);
    add(SAFE,  1'b0, SAFE,  1'b0, 3'd0, 1);
    // Test 2/5: conflict, flashing 1,1,0,0,1, ignored and accepted clears.
    add(MG_SG, 1'b0, SAFE,  1'b1, 3'd2, 1);
    add(SAFE,  1'b0, SAFE,  1'b1, 3'd2, 1);
    add(MG_SR, 1'b1, 6'd0,  1'b1, 3'd2, 1);
    add(SAFE,  1'b0, 6'd0,  1'b1, 3'd2, 1);
    add(SAFE,  1'b0, SAFE,  1'b1, 3'd2, 1);
    add(SAFE,  1'b1, SAFE,  1'b0, 3'd0, 1);
    // First move after clear is unchecked; its yellow is never short.
    add(MY_SR, 1'b0, MY_SR, 1'b0, 3'd0, 1);
    add(SAFE,  1'b0, SAFE,  1'b0, 3'd0, 1);
    // Test 3: G->R, short yellow, simultaneous not-one-hot + conflict.
    add(MG_SR, 1'b0, MG_SR, 1'b0, 3'd0, 1);
    add(SAFE,  1'b0, SAFE,  1'b1, 3'd3, 1);
    add(SAFE,  1'b1, SAFE,  1'b0, 3'd0, 1);
    add(MG_SR, 1'b0, MG_SR, 1'b0, 3'd0, 1);
    add(MY_SR, 1'b0, MY_SR, 1'b0, 3'd0, 1);
    add(SAFE,  1'b0, SAFE,  1'b1, 3'd4, 1);
    add(SAFE,  1'b1, SAFE,  1'b0, 3'd0, 1);
    add(BOTH,  1'b0, SAFE,  1'b1, 3'd1, 1);
    add(SAFE,  1'b1, SAFE,  1'b0, 3'd0, 1);

    #12;
    check("reset_state", {6'd0, o_vec, flt, code}, {6'd0, SAFE, 1'b0, 3'd0});
    rst = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].vec, tbl[i].clr, "model");
      check("table", {6'd0, o_vec, flt, code}, {6'd0, tbl[i].eo, tbl[i].ef, tbl[i].ec});
    end

    // Test 4: 15-cycle hold is fine, 16-cycle hold trips the watchdog.
    for (int i = 0; i < 15; i++) step(MG_SR, 1'b0, "wd15");
    check("wd15_no_fault", {15'd0, flt}, 16'd0);
    step(MY_SR, 1'b0, "wd15_change");
    check("wd15_change_no_fault", {15'd0, flt}, 16'd0);
    step(MY_SR, 1'b0, "seq");
    step(SAFE, 1'b0, "seq");
    for (int i = 0; i < 15; i++) step(MR_SG, 1'b0, "wd16");
    check("wd16_before", {15'd0, flt}, 16'd0);
    step(MR_SG, 1'b0, "wd16");
    check("wd16_trip", {12'd0, flt, code}, {12'd0, 1'b1, 3'd5});
    step(SAFE, 1'b1, "wd_clear");

    // Test 6: asynchronous reset in the middle of flashing.
    step(MG_SG, 1'b0, "flash");
    step(SAFE, 1'b0, "flash");
    step(SAFE, 1'b0, "flash");
    #3 rst = 1'b0;
    #1 check("async_rst", {6'd0, o_vec, flt, code}, {6'd0, SAFE, 1'b0, 3'd0});
    #2 rst = 1'b1;
    model_reset();
    step(MG_SR, 1'b0, "post_rst");
    step(MY_SR, 1'b0, "post_rst");
    step(MY_SR, 1'b0, "post_rst");
    step(SAFE, 1'b0, "post_rst");
    step(MR_SG, 1'b0, "post_rst");
    check("post_rst_no_fault", {15'd0, flt}, 16'd0);

    // Randomized traffic against the model.
    rand_phase(800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
